// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and execute training signals of the branch predictor
interface branch_predictor_if #(
    parameter int PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] pcF;
    logic                prediction;
    logic [PC_WIDTH-1:0] predictedTarget;
    logic                hit;
    logic                branchE;
    logic                takenBranchE;
    logic [PC_WIDTH-1:0] pcE;
    logic [PC_WIDTH-1:0] targetE;

    // pipeline side: drives the fetch PC and the resolved branch, consumes the prediction
    modport master (
        output pcF,
        input  prediction,
        input  predictedTarget,
        input  hit,
        output branchE,
        output takenBranchE,
        output pcE,
        output targetE
    );

    // predictor side
    modport slave (
        input  pcF,
        output prediction,
        output predictedTarget,
        output hit,
        input  branchE,
        input  takenBranchE,
        input  pcE,
        input  targetE
    );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating direction counters
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int PC_WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

    logic                  r_valid  [ENTRIES];
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [PC_WIDTH-1:0]   r_target [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];

    logic [INDEX_BITS-1:0] w_idx_f;
    logic [TAG_W-1:0]      w_tag_f;
    logic [INDEX_BITS-1:0] w_idx_e;
    logic [TAG_W-1:0]      w_tag_e;
    logic                  w_hit_f;
    logic                  w_match_e;
    logic [1:0]            w_ctr_e;
    logic [1:0]            w_ctr_inc;
    logic [1:0]            w_ctr_dec;

    assign w_idx_f = bp.pcF[INDEX_BITS+1:2];
    assign w_tag_f = bp.pcF[PC_WIDTH-1:INDEX_BITS+2];
    assign w_idx_e = bp.pcE[INDEX_BITS+1:2];
    assign w_tag_e = bp.pcE[PC_WIDTH-1:INDEX_BITS+2];

    // fetch lookup reads the registered table directly, so a same-cycle update is not visible
    always_comb begin
        w_hit_f            = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
        bp.hit             = w_hit_f;
        bp.prediction      = w_hit_f & r_ctr[w_idx_f][1];
        bp.predictedTarget = w_hit_f ? r_target[w_idx_f] : '0;
    end

    // execute-side match and saturating next-counter values
    always_comb begin
        w_match_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
        w_ctr_e   = r_ctr[w_idx_e];
        w_ctr_inc = (w_ctr_e == 2'b11) ? 2'b11 : w_ctr_e + 2'b01;
        w_ctr_dec = (w_ctr_e == 2'b00) ? 2'b00 : w_ctr_e - 2'b01;
    end

    // reset clears every entry; otherwise train at most the one entry selected by pcE
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (bp.branchE) begin
            if (w_match_e) begin
                if (bp.takenBranchE) begin
                    r_ctr[w_idx_e]    <= w_ctr_inc;
                    r_target[w_idx_e] <= bp.targetE;
                end else begin
                    r_ctr[w_idx_e]    <= w_ctr_dec;
                end
            end else if (bp.takenBranchE) begin
                // a not-taken miss leaves an aliased entry of another branch alone
                r_valid[w_idx_e]  <= 1'b1;
                r_tag[w_idx_e]    <= w_tag_e;
                r_target[w_idx_e] <= bp.targetE;
                r_ctr[w_idx_e]    <= 2'b10;
            end
        end
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor, combining a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It generates `prediction` and `predictedTarget` for the instruction at `pcF`. It is trained non-speculatively from the execute stage with the resolved outcome (`takenBranch`) of the same branch. The hazard unit compares that resolved outcome against the carried-along prediction to raise Flush, so this block is the producing end of the prediction/resolution loop.

## Interface
- `INDEX_BITS`, 6: BTB index width; the table holds 2^INDEX_BITS entries.
- `PC_WIDTH`, 32: program counter width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `pcF`  in  PC_WIDTH  fetch PC being looked up.
- `prediction`  out  1  1 = predict taken.
- `predictedTarget`  out  PC_WIDTH  target to fetch when `prediction`=1; 0 when there is no hit.
- `hit`  out  1  a valid entry with a matching tag exists for `pcF`.
- `branchE`  in  1  a resolved conditional branch is in execute; this is the update enable.
- `takenBranchE`  in  1  resolved direction of that branch.
- `pcE`  in  PC_WIDTH  PC of the resolving branch.
- `targetE`  in  PC_WIDTH  resolved taken-target of the branch.

## Operation
- Index is `pc[INDEX_BITS+1:2]`.
- Tag is `pc[PC_WIDTH-1:INDEX_BITS+2]`.
- Each entry holds:
  - valid, 1 bit
  - tag
  - target, PC_WIDTH bits
  - ctr, 2 bits
- ctr encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Lookup is purely combinational from `pcF`:
  - `hit` = valid[idxF] & (tag[idxF] == tagF).
  - `prediction` = hit & ctr[idxF][1].
  - `predictedTarget` = hit ? target[idxF] : 0.
- Update happens on a rising edge with `rst`=1 and `branchE`=1. Let idxE/tagE come from `pcE` and matchE = valid[idxE] & tag == tagE:
  - matchE & taken: ctr = sat_inc(ctr), target = `targetE`.
  - matchE & not taken: ctr = sat_dec(ctr); target unchanged.
  - !matchE & taken: allocate or replace the entry. Set valid=1, tag=tagE, target=`targetE`, ctr=10.
  - !matchE & not taken: no change. An aliased entry belonging to a different branch is not disturbed.
- Saturation: sat_inc(11)=11 and sat_dec(00)=00. Counters never wrap.
- `branchE`=0: the table holds its contents. Bubbles from a Stall or Flush arrive with `branchE`=0 and cause no training.
- Reset (`rst`=0 at an edge): every entry gets valid=0, tag=0, target=0, ctr=01. Reset overrides a simultaneous update.
- Outputs after reset: `hit`=0, `prediction`=0, `predictedTarget`=0 for every `pcF`.
- Reset asserted mid-training discards all history. No partially updated entry survives.

## Timing
- Lookup latency is 0 cycles; outputs follow `pcF` combinationally within the same cycle.
- Update latency is 1 cycle; the new entry state is visible to lookups from the cycle after the training edge.
- Simultaneous read and write of the same index (idxF == idxE in the same cycle): the lookup returns the pre-update contents. There is no write-to-read bypass.
- One update per cycle at most. There is no handshake: `branchE` is a single-cycle strobe per resolved branch, supplied by the execute pipeline register.
- Only one index is written per edge. All other entries are untouched.

## Test plan
- Reset then lookup: hold `rst`=0 for 2 cycles, release, drive `pcF`=0x0000_0040. Required: `hit`=0, `prediction`=0, `predictedTarget`=0.
- Allocate and predict:
  - Drive `branchE`=1, taken=1, `pcE`=0x40, `targetE`=0x100 for one edge.
  - Same cycle, `pcF`=0x40: required `prediction`=0 (no bypass).
  - Next cycle, `pcF`=0x40: required `hit`=1, `prediction`=1, target 0x100.
- Saturation:
  - Train 0x40 taken ×3: ctr goes 10→11→11, `prediction`=1.
  - Then not-taken ×1: ctr 10, `prediction`=1.
  - Then not-taken ×2: ctr 01, then 00, `prediction`=0, `hit`=1.
  - Then not-taken once more: ctr stays 00.
  - Then taken ×2: ctr 01, then 10, `prediction`=1.
- Aliasing (INDEX_BITS=6): 0x40 is allocated. Train `pcE`=0x140 (same index, different tag).
  - Not-taken: `pcF`=0x40 still hits with target 0x100.
  - Then taken with target 0x200: `pcF`=0x40 gives `hit`=0; `pcF`=0x140 gives `hit`=1, target 0x200, `prediction`=1.
- Target refresh: matching taken update on 0x40 with `targetE`=0x180. Required: next-cycle `predictedTarget`=0x180 and ctr increments.
- Reset during training: `rst`=0 on the same edge as `branchE`=1 for 0x40. Required: `pcF`=0x40 misses afterwards, and all previously trained entries miss.
